// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//
// Memory end of the pipeline's data-memory request/response handshake.
// Takes one load or store at a time, answers it a fixed LATENCY cycles after
// acceptance, and performs byte/half/word accesses on a word-organised RAM
// with byte-lane steering and sign/zero extension of loads.  Misaligned,
// out-of-range and illegal-size accesses come back with resp_err set.
//
// Ports:
//   clk           clock, everything on the rising edge
//   reset         synchronous active-high reset
//   req_valid     request present
//   req_ready     responder can accept this cycle
//   req_we        1 = store, 0 = load
//   req_addr      byte address
//   req_wdata     store data, right-aligned
//   req_size      00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned  loads zero-extend when 1, sign-extend when 0
//   resp_valid    one-cycle response pulse
//   resp_rdata    load result, 0 for stores and errors
//   resp_err      access fault, meaningful only with resp_valid
// ---------------------------------------------------------------------------
module data_mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          IDXW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] MEM_BYTES = 32'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } stateT;

    stateT             r_state;
    logic [3:0]        r_count;
    logic              r_ready;
    logic              r_respValid;
    logic [31:0]       r_respData;
    logic              r_respErr;
    logic [31:0]       r_pendData;
    logic              r_pendErr;
    logic [31:0]       r_mem [DEPTH_WORDS];

    logic              w_accept;
    logic              w_write;
    logic [31:0]       w_offset;
    logic [IDXW-1:0]   w_index;
    logic              w_err;
    logic [31:0]       w_rword;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_respData;
    logic [3:0]        w_be;
    logic [31:0]       w_wword;
    logic [3:0]        w_countNext;

    assign req_ready  = r_ready;
    assign resp_valid = r_respValid;
    assign resp_rdata = r_respData;
    assign resp_err   = r_respErr;

    assign w_accept    = req_valid & r_ready;
    assign w_write     = w_accept & req_we & ~w_err & ~reset;
    assign w_countNext = r_count - 4'd1;

    // Decode the request on the input side.  The whole response is worked out
    // here at the accept edge from the pre-write RAM word, so a later store
    // can never disturb the result of a load that is still in flight.
    always_comb begin
        w_offset   = req_addr - BASE_ADDR;
        w_index    = w_offset[IDXW+1:2];
        w_err      = (req_size == 2'b11)
                   | ((req_size == 2'b01) & req_addr[0])
                   | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00))
                   | (w_offset >= MEM_BYTES);
        w_rword    = r_mem[w_index];
        w_byte     = w_rword[{req_addr[1:0], 3'b000} +: 8];
        w_half     = req_addr[1] ? w_rword[31:16] : w_rword[15:0];
        w_respData = 32'h0;
        if (!w_err && !req_we) begin
            case (req_size)
                2'b00:   w_respData = {{24{w_byte[7]  & ~req_unsigned}}, w_byte};
                2'b01:   w_respData = {{16{w_half[15] & ~req_unsigned}}, w_half};
                default: w_respData = w_rword;
            endcase
        end
    end

    // Store data is replicated across all lanes so only the byte enables
    // decide which lanes actually change.
    always_comb begin
        w_be    = 4'b0000;
        w_wword = req_wdata;
        case (req_size)
            2'b00: begin
                w_be[req_addr[1:0]] = 1'b1;
                w_wword = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                w_wword = {2{req_wdata[15:0]}};
            end
            default: w_be = 4'b1111;
        endcase
    end

    // Storage is not reset; stores commit at their accept edge.
    always_ff @(posedge clk) begin
        if (w_write) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_index][8*b +: 8] <= w_wword[8*b +: 8];
                end
            end
        end
    end

    // Control FSM.  The counter holds the number of remaining WAIT cycles; the
    // response register is loaded on the edge that enters RESP, and RESP also
    // accepts so back-to-back traffic sustains one request per LATENCY cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_count     <= 4'd0;
            r_ready     <= 1'b0;
            r_respValid <= 1'b0;
            r_respData  <= 32'h0;
            r_respErr   <= 1'b0;
            r_pendData  <= 32'h0;
            r_pendErr   <= 1'b0;
        end else begin
            r_respValid <= 1'b0;
            r_respData  <= 32'h0;
            r_respErr   <= 1'b0;
            case (r_state)
                S_WAIT: begin
                    if (w_countNext == 4'd0) begin
                        r_state     <= S_RESP;
                        r_count     <= 4'd0;
                        r_ready     <= 1'b1;
                        r_respValid <= 1'b1;
                        r_respData  <= r_pendData;
                        r_respErr   <= r_pendErr;
                    end else begin
                        r_count <= w_countNext;
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_pendData <= w_respData;
                        r_pendErr  <= w_err;
                        if (LATENCY == 1) begin
                            r_state     <= S_RESP;
                            r_ready     <= 1'b1;
                            r_respValid <= 1'b1;
                            r_respData  <= w_respData;
                            r_respErr   <= w_err;
                        end else begin
                            r_state <= S_WAIT;
                            r_count <= 4'(LATENCY - 1);
                            r_ready <= 1'b0;
                        end
                    end else begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
//
// Self-checking bench for data_mem_responder: reset values, directed vectors
// from a table, randomized traffic against a byte-array reference memory,
// back-to-back throughput and reset in the middle of a load.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

    localparam int          DEPTH_WORDS = 1024;
    localparam int          LATENCY     = 2;
    localparam logic [31:0] BASE_ADDR   = 32'h0000_0000;
    localparam int          MEM_BYTES   = 4 * DEPTH_WORDS;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int errCount   = 0;
    int checkCount = 0;

    logic [7:0] refMem [MEM_BYTES];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] expData;
        logic        expErr;
    } vecT;

    vecT vecs[$];

    data_mem_responder #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .LATENCY     (LATENCY),
        .BASE_ADDR   (BASE_ADDR)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Reference memory: little-endian byte array, extended per the access size.
    function automatic void refAccess(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                      input logic [1:0] size, input logic uns,
                                      output logic [31:0] d, output logic e);
        logic [31:0] off;
        logic [31:0] v;
        int          nBytes;
        off    = addr - BASE_ADDR;
        e      = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
                 (size == 2'd2 && addr % 4 != 0) || (off >= 32'(MEM_BYTES));
        nBytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        d      = 32'h0;
        if (!e) begin
            if (we) begin
                for (int i = 0; i < nBytes; i++) refMem[int'(off) + i] = wdata[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < nBytes; i++) v[8*i +: 8] = refMem[int'(off) + i];
                if (!uns && nBytes == 1 && v[7])  v = v | 32'hFFFF_FF00;
                if (!uns && nBytes == 2 && v[15]) v = v | 32'hFFFF_0000;
                d = v;
            end
        end
    endfunction

    // Issue one request, wait for it to be accepted and answered, and check
    // the accept-to-response latency plus the single-cycle pulse width.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [1:0] size, input logic uns,
                                 output logic [31:0] d, output logic e);
        int waitN;
        int lat;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
        waitN = 0;
        while (!req_ready && waitN < 20) begin
            @(negedge clk);
            waitN++;
        end
        d = 32'h0;
        e = 1'b1;
        if (!req_ready) begin
            checkOutput("acceptTimeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = k;
                d   = resp_rdata;
                e   = resp_err;
                break;
            end
        end
        checkOutput("latency", 32'(lat), 32'(LATENCY));
        @(negedge clk);
        checkOutput("pulseWidth", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        logic [31:0] md;
        logic        me;
        logic [31:0] bbExp[$];
        vecT         bb[4];
        int          acc;
        int          pulses;
        int          accEdge[4];
        logic        prevValid;
        logic        rdy;
        logic        sawValid;
        int          waitN;

        reset        = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;

        // Reset values while reset is held.
        repeat (3) @(negedge clk);
        checkOutput("rstReady", 32'(req_ready), 32'd0);
        checkOutput("rstValid", 32'(resp_valid), 32'd0);
        checkOutput("rstData", resp_rdata, 32'h0);
        checkOutput("rstErr", 32'(resp_err), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("readyAfterRst", 32'(req_ready), 32'd1);

        // Store word with cycle-by-cycle timing checks.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hDEAD_BEEF;
        req_size  = 2'b10; req_unsigned = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        refAccess(1'b1, 32'h10, 32'hDEAD_BEEF, 2'b10, 1'b0, md, me);
        @(negedge clk);
        checkOutput("waitReady", 32'(req_ready), 32'd0);
        checkOutput("waitValid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        checkOutput("stValid", 32'(resp_valid), 32'd1);
        checkOutput("stData", resp_rdata, 32'h0);
        checkOutput("stErr", 32'(resp_err), 32'd0);
        checkOutput("respReady", 32'(req_ready), 32'd1);
        @(negedge clk);
        checkOutput("stPulse", 32'(resp_valid), 32'd0);

        // Directed vectors.
        vecs.push_back('{1'b0, 32'h13,   32'h0,         2'b00, 1'b0, 32'hFFFF_FFDE, 1'b0});
        vecs.push_back('{1'b0, 32'h13,   32'h0,         2'b00, 1'b1, 32'h0000_00DE, 1'b0});
        vecs.push_back('{1'b0, 32'h10,   32'h0,         2'b01, 1'b0, 32'hFFFF_BEEF, 1'b0});
        vecs.push_back('{1'b0, 32'h12,   32'h0,         2'b01, 1'b1, 32'h0000_DEAD, 1'b0});
        vecs.push_back('{1'b1, 32'h11,   32'hAAAA_AA55, 2'b00, 1'b0, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 32'h10,   32'h0,         2'b10, 1'b0, 32'hDEAD_55EF, 1'b0});
        vecs.push_back('{1'b0, 32'h11,   32'h0,         2'b01, 1'b0, 32'h0,         1'b1});
        vecs.push_back('{1'b0, 32'h12,   32'h0,         2'b10, 1'b0, 32'h0,         1'b1});
        vecs.push_back('{1'b0, 32'h10,   32'h0,         2'b11, 1'b0, 32'h0,         1'b1});
        vecs.push_back('{1'b0, 32'h1000, 32'h0,         2'b10, 1'b0, 32'h0,         1'b1});
        vecs.push_back('{1'b1, 32'h12,   32'h1234_5678, 2'b10, 1'b0, 32'h0,         1'b1});
        vecs.push_back('{1'b0, 32'h10,   32'h0,         2'b10, 1'b0, 32'hDEAD_55EF, 1'b0});
        vecs.push_back('{1'b1, 32'h12,   32'hFFFF_CAFE, 2'b01, 1'b0, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 32'h10,   32'h0,         2'b10, 1'b0, 32'hCAFE_55EF, 1'b0});
        vecs.push_back('{1'b0, 32'h12,   32'h0,         2'b00, 1'b0, 32'hFFFF_FFFE, 1'b0});
        vecs.push_back('{1'b1, 32'hFFF,  32'h0000_00AB, 2'b00, 1'b0, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 32'hFFF,  32'h0,         2'b00, 1'b1, 32'h0000_00AB, 1'b0});
        vecs.push_back('{1'b1, 32'hFFFF_FFFC, 32'h1,    2'b10, 1'b0, 32'h0,         1'b1});
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].uns, d, e);
            refAccess(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].uns, md, me);
            checkOutput($sformatf("vec%0dData", i), d, vecs[i].expData);
            checkOutput($sformatf("vec%0dErr", i), 32'(e), 32'(vecs[i].expErr));
        end

        // Fill the random window 0x00..0x3F with known words.
        for (int w = 0; w < 16; w++) begin
            refAccess(1'b1, 32'(4 * w), $urandom, 2'b10, 1'b0, md, me);
            applyStimulus(1'b1, 32'(4 * w), {refMem[4*w+3], refMem[4*w+2], refMem[4*w+1], refMem[4*w]},
                          2'b10, 1'b0, d, e);
            checkOutput("fillErr", 32'(e), 32'd0);
        end

        // Randomized traffic against the reference memory.
        for (int i = 0; i < 80; i++) begin
            logic        rWe;
            logic [31:0] rAddr;
            logic [31:0] rData;
            logic [1:0]  rSize;
            logic        rUns;
            rWe   = 1'($urandom_range(0, 1));
            rSize = 2'($urandom_range(0, 3));
            rUns  = 1'($urandom_range(0, 1));
            rData = $urandom;
            if ($urandom_range(0, 9) < 8) begin
                rAddr = 32'($urandom_range(0, 63));
                if ($urandom_range(0, 1) == 1 && rSize != 2'd3) rAddr = rAddr & ~((32'd1 << rSize) - 32'd1);
            end else begin
                rAddr = $urandom | 32'h0001_0000;
            end
            refAccess(rWe, rAddr, rData, rSize, rUns, md, me);
            applyStimulus(rWe, rAddr, rData, rSize, rUns, d, e);
            checkOutput($sformatf("rnd%0dData", i), d, md);
            checkOutput($sformatf("rnd%0dErr", i), 32'(e), 32'(me));
        end

        // Back-to-back loads with req_valid held high throughout.
        bb[0] = '{1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0};
        bb[1] = '{1'b0, 32'h26, 32'h0, 2'b01, 1'b0, 32'h0, 1'b0};
        bb[2] = '{1'b0, 32'h29, 32'h0, 2'b00, 1'b1, 32'h0, 1'b0};
        bb[3] = '{1'b0, 32'h2C, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            refAccess(bb[i].we, bb[i].addr, bb[i].wdata, bb[i].size, bb[i].uns, md, me);
            bbExp.push_back(md);
        end
        @(negedge clk);
        req_valid = 1'b1; req_we = bb[0].we; req_addr = bb[0].addr; req_size = bb[0].size;
        req_unsigned = bb[0].uns;
        acc = 0; pulses = 0; prevValid = 1'b0;
        for (int c = 0; c < 14; c++) begin
            if (c > 0) @(negedge clk);
            if (resp_valid) begin
                checkOutput("bbWidth", 32'(prevValid), 32'd0);
                if (pulses < 4) checkOutput($sformatf("bbData%0d", pulses), resp_rdata, bbExp[pulses]);
                pulses++;
            end
            prevValid = resp_valid;
            rdy = req_ready;
            @(posedge clk);
            if (rdy && req_valid) begin
                accEdge[acc] = c;
                acc++;
                #1;
                if (acc < 4) begin
                    req_we = bb[acc].we; req_addr = bb[acc].addr; req_size = bb[acc].size;
                    req_unsigned = bb[acc].uns;
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        checkOutput("bbAccepts", 32'(acc), 32'd4);
        checkOutput("bbPulses", 32'(pulses), 32'd4);
        for (int i = 1; i < 4 && i < acc; i++)
            checkOutput($sformatf("bbSpacing%0d", i), 32'(accEdge[i] - accEdge[i-1]), 32'(LATENCY));

        // Reset during the WAIT cycle of a load.
        applyStimulus(1'b1, 32'h40, 32'hA5A5_5A5A, 2'b10, 1'b0, d, e);
        refAccess(1'b1, 32'h40, 32'hA5A5_5A5A, 2'b10, 1'b0, md, me);
        checkOutput("preRstStErr", 32'(e), 32'd0);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40; req_size = 2'b10; req_unsigned = 1'b0;
        waitN = 0;
        while (!req_ready && waitN < 20) begin
            @(negedge clk);
            waitN++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checkOutput("midWaitReady", 32'(req_ready), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midRstReady", 32'(req_ready), 32'd0);
        checkOutput("midRstValid", 32'(resp_valid), 32'd0);
        reset = 1'b0;
        sawValid = 1'b0;
        @(negedge clk);
        if (resp_valid) sawValid = 1'b1;
        checkOutput("postRstReady", 32'(req_ready), 32'd1);
        repeat (5) begin
            @(negedge clk);
            if (resp_valid) sawValid = 1'b1;
        end
        checkOutput("droppedResp", 32'(sawValid), 32'd0);
        applyStimulus(1'b0, 32'h40, 32'h0, 2'b10, 1'b0, d, e);
        checkOutput("keptStore", d, 32'hA5A5_5A5A);
        checkOutput("keptStoreErr", 32'(e), 32'd0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
